// File: rtl/reco_pkg.sv
// Shared types and constants for the recogniser run controller.
package reco_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ARM   = 3'd2,
    RUN   = 3'd3,
    LATCH = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Largest value the 4-digit BCD display can show.
  localparam logic [15:0] SAT_MAX = 16'd9999;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector.
// After reset, d must be seen low at least once before a pulse can fire.
// As a result, a level held high through reset release never looks like a new edge.
module rise_detect (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic pulse
);

  logic prev;
  logic armed;

  // Remember the last sampled level, and whether a low level has been seen since reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev <= d;
      if (!d) armed <= 1'b1;
    end
  end

  assign pulse = d & ~prev & armed;

endmodule

// File: rtl/reco_ctrl.sv
// Run controller for the pattern recogniser.
// Each run clears the recogniser, loads the pattern and counts a fixed window.
// It then latches the saturated match count for the BCD display.
module reco_ctrl
  import reco_pkg::*;
#(
  parameter int CLR_CYCLES = 2,
  parameter int RUN_CYCLES = 64
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] sw,
  input  logic [15:0] reco_count,
  output logic        reco_clr,
  output logic        reco_en,
  output logic [15:0] reco_sw,
  output logic [13:0] result,
  output logic        overflow,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] CLR_LOAD = 16'(CLR_CYCLES - 1);
  localparam logic [15:0] RUN_LOAD = 16'(RUN_CYCLES - 1);

  state_t      state;
  state_t      nxt;
  logic [15:0] cnt;
  logic        start_pulse;
  logic        run_begin;

  // Clamp the recogniser count to what the display can show.
  function automatic logic [13:0] sat_count(input logic [15:0] v);
    if (v > SAT_MAX) return SAT_MAX[13:0];
    return v[13:0];
  endfunction

  rise_detect u_start_edge (
    .clk   (clk),
    .clr   (clr),
    .d     (start),
    .pulse (start_pulse)
  );

  // Next-state decode: abort overrides everything, including a coincident start edge.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start_pulse) nxt = CLEAR;
      CLEAR:   if (cnt == 16'd0) nxt = ARM;
      ARM:     nxt = RUN;
      RUN:     if (cnt == 16'd0) nxt = LATCH;
      LATCH:   nxt = DONE;
      DONE:    if (start_pulse) nxt = CLEAR;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end

  // A run begins only from IDLE or DONE; start edges in busy states fall through unused.
  assign run_begin = (nxt == CLEAR) && (state == IDLE || state == DONE);

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= nxt;
  end

  // Shared down-counter, reloaded on entry to CLEAR and RUN.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)                            cnt <= 16'd0;
    else if (abort)                     cnt <= 16'd0;
    else if (run_begin)                 cnt <= CLR_LOAD;
    else if (state == ARM && nxt == RUN) cnt <= RUN_LOAD;
    else if (cnt != 16'd0)              cnt <= cnt - 16'd1;
  end

  // Capture the pattern at run start so sw may change freely during the run.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)            reco_sw <= 16'd0;
    else if (run_begin) reco_sw <= sw;
  end

  // Latch the result once per run; it holds across later runs until their own LATCH.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      result   <= 14'd0;
      overflow <= 1'b0;
    end else if (abort) begin
      result   <= 14'd0;
      overflow <= 1'b0;
    end else if (state == LATCH) begin
      result   <= sat_count(reco_count);
      overflow <= (reco_count > SAT_MAX);
    end
  end

  assign reco_clr = (state == CLEAR);
  assign reco_en  = (state == ARM);
  assign busy     = (state == CLEAR) || (state == ARM) || (state == RUN) || (state == LATCH);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_reco_ctrl.sv
// Bench for reco_ctrl.
// Stimulus pushes the expected per-run outcome into a queue.
// A monitor pops it on each rising edge of done and checks the run.
module tb_reco_ctrl;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] sw = 16'd0;
  logic [15:0] reco_count = 16'd0;
  logic        reco_clr, reco_en, overflow, busy, done;
  logic [15:0] reco_sw;
  logic [13:0] result;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [13:0] res;
    logic        ovf;
    int          nclr;
    int          nen;
    int          nbusy;
    logic [15:0] sw;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  reco_ctrl dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .abort      (abort),
    .sw         (sw),
    .reco_count (reco_count),
    .reco_clr   (reco_clr),
    .reco_en    (reco_en),
    .reco_sw    (reco_sw),
    .result     (result),
    .overflow   (overflow),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: measure each run from busy rising, score it when done rises.
  logic busy_q = 1'b0;
  logic done_q = 1'b0;
  int   n_busy = 0, n_clr = 0, n_en = 0;
  always @(negedge clk) begin
    if (busy && !busy_q) begin
      n_busy = 0; n_clr = 0; n_en = 0;
    end
    n_busy += int'(busy);
    n_clr  += int'(reco_clr);
    n_en   += int'(reco_en);
    if (done && !done_q) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result",    32'(result),  32'(e.res));
        check("overflow",  32'(overflow), 32'(e.ovf));
        check("clr_len",   32'(n_clr),   32'(e.nclr));
        check("en_pulses", 32'(n_en),    32'(e.nen));
        check("busy_len",  32'(n_busy),  32'(e.nbusy));
        check("reco_sw",   32'(reco_sw), 32'(e.sw));
      end
    end
    busy_q = busy;
    done_q = done;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle start pulse, then scramble sw to prove it is not re-sampled.
  task automatic run_start(input logic [15:0] sw_v, input logic [15:0] cnt_v,
                           input logic [13:0] res, input logic ovf, input bit expect_done);
    exp_t e;
    tick(1);
    sw         = sw_v;
    reco_count = cnt_v;
    start      = 1'b1;
    if (expect_done) begin
      e.res = res; e.ovf = ovf; e.nclr = 2; e.nen = 1; e.nbusy = 68; e.sw = sw_v;
      q.push_back(e);
    end
    tick(1);
    start = 1'b0;
    sw    = ~sw_v;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check(name, 32'd0, 32'd1);
  endtask

  initial begin
    // Reset state
    tick(2);
    @(negedge clk);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_reco_clr", 32'(reco_clr), 32'd0);
    check("rst_reco_en",  32'(reco_en),  32'd0);
    check("rst_reco_sw",  32'(reco_sw),  32'd0);
    check("rst_result",   32'(result),   32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    tick(1);
    clr = 1'b0;
    tick(2);

    // Basic run: count 37
    run_start(16'hB2DB, 16'd37, 14'd37, 1'b0, 1'b1);
    wait_done("timeout_run1");

    // Restart from DONE with a saturating count; a second edge arrives mid-run
    run_start(16'h00FF, 16'h3000, 14'd9999, 1'b1, 1'b1);
    @(negedge clk);
    check("restart_done_low", 32'(done),    32'd0);
    check("restart_reco_sw",  32'(reco_sw), 32'h00FF);
    check("restart_hold_res", 32'(result),  32'd37);
    tick(20);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("timeout_run2");
    tick(5);
    @(negedge clk);
    check("no_queued_run_done", 32'(done), 32'd1);
    check("no_queued_run_busy", 32'(busy), 32'd0);

    // Abort in RUN cycle 10
    run_start(16'h0F0F, 16'd500, 14'd0, 1'b0, 1'b0);
    begin
      bit seen_en = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (reco_en) begin
          seen_en = 1'b1;
          break;
        end
      end
      if (!seen_en) check("timeout_arm", 32'd0, 32'd1);
    end
    tick(10);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy",     32'(busy),     32'd0);
    check("abort_done",     32'(done),     32'd0);
    check("abort_result",   32'(result),   32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    begin
      int en_cnt = 0, done_cnt = 0;
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        en_cnt   += int'(reco_en);
        done_cnt += int'(done);
      end
      check("abort_no_en",   32'(en_cnt),   32'd0);
      check("abort_no_done", 32'(done_cnt), 32'd0);
    end

    // Abort wins over a coincident start edge
    tick(1);
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    @(negedge clk);
    check("abort_vs_start", 32'(busy), 32'd0);
    tick(3);
    start = 1'b0;

    // Start held high through reset release must not start a run
    tick(1);
    clr   = 1'b1;
    start = 1'b1;
    tick(2);
    clr = 1'b0;
    tick(10);
    @(negedge clk);
    check("held_start_busy", 32'(busy), 32'd0);
    check("held_start_done", 32'(done), 32'd0);
    start = 1'b0;
    tick(1);
    run_start(16'h1357, 16'd9999, 14'd9999, 1'b0, 1'b1);
    wait_done("timeout_run3");

    // One above the saturation point
    run_start(16'h8001, 16'd10000, 14'd9999, 1'b1, 1'b1);
    wait_done("timeout_run4");

    // Reset during RUN abandons the run with nothing latched
    run_start(16'hAAAA, 16'd77, 14'd0, 1'b0, 1'b0);
    tick(30);
    clr = 1'b1;
    #2;
    check("midrst_busy",     32'(busy),     32'd0);
    check("midrst_result",   32'(result),   32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_reco_sw",  32'(reco_sw),  32'd0);
    tick(2);
    clr = 1'b0;
    tick(80);
    @(negedge clk);
    check("midrst_no_done", 32'(done), 32'd0);
    check("queue_empty",    32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reco_ctrl.md
RECO_CTRL -- requirements
Module: reco_ctrl

Interface
REQ-001 SHALL have parameter CLR_CYCLES, default 2, number of cycles reco_clr is held high (legal range 1..255).
REQ-002 SHALL have parameter RUN_CYCLES, default 64, recognition window length in cycles (legal range 1..65535).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  synchronous level request; rising edge starts a run.
REQ-006 SHALL have port abort  input  1  synchronous level; forces return to IDLE.
REQ-007 SHALL have port sw  input  16  pattern to be recognised.
REQ-008 SHALL have port reco_count  input  16  match count from the recogniser.
REQ-009 SHALL have port reco_clr  output  1  clear to the recogniser.
REQ-010 SHALL have port reco_en  output  1  one-cycle enable/load pulse to the recogniser.
REQ-011 SHALL have port reco_sw  output  16  pattern presented to the recogniser.
REQ-012 SHALL have port result  output  14  latched count, saturated at 9999, for the BCD converter.
REQ-013 SHALL have port overflow  output  1  latched count exceeded 9999.
REQ-014 SHALL have port busy  output  1  run in progress.
REQ-015 SHALL have port done  output  1  result valid.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, CLEAR, ARM, RUN, LATCH, DONE; every output decoded from registered state and data registers only.
REQ-017 SHALL detect start rising edge as start=1 with registered previous start=0; the edge is accepted only in IDLE or DONE.
REQ-018 On accepted edge at cycle t: SHALL capture sw into reco_sw and enter CLEAR at t+1.
REQ-019 In CLEAR: reco_clr=1 for exactly CLR_CYCLES cycles, then ARM.
REQ-020 In ARM: reco_en=1 for exactly one cycle, then RUN.
REQ-021 In RUN: SHALL count RUN_CYCLES cycles (16-bit counter, loaded at RUN entry), then LATCH.
REQ-022 In LATCH (one cycle): result <= min(reco_count, 9999); overflow <= (reco_count > 9999); then DONE.
REQ-023 busy SHALL be 1 in CLEAR, ARM, RUN, LATCH, else 0; done SHALL be 1 only in DONE.
REQ-024 result and overflow SHALL hold their value from LATCH until the next LATCH, a reset, or an abort (abort clears both to 0).
REQ-025 Start edges while busy=1 SHALL be ignored and not queued.
REQ-026 abort=1 in any state SHALL force IDLE next cycle, deassert reco_clr/reco_en, and clear result, overflow, and the counter.
REQ-027 If abort and a start edge coincide, abort SHALL win; the start edge is discarded.
REQ-028 A start edge in DONE SHALL begin a new run (done falls at t+1).
REQ-029 reco_sw SHALL change only on an accepted start edge; stable during a run regardless of sw.

Reset
REQ-030 While clr=1: state=IDLE, reco_clr=0, reco_en=0, reco_sw=0, result=0, overflow=0, busy=0, done=0, counters=0, previous start=0.
REQ-031 Reset asserted mid-run SHALL abort immediately (asynchronously); no partial result is latched.
REQ-032 start held high through reset release SHALL NOT trigger a run (the previous-start register must see a 0 first).

Structure
REQ-033 Shared package reco_pkg SHALL hold the state enum and the constant SAT_MAX=9999.
REQ-034 The edge detector SHALL be the sub-module rise_detect (clk, clr, d, pulse).

Verification
REQ-035 Defaults; sw=16'hB2DB, start pulse, reco_count=37 -> reco_clr high 2 cycles, reco_en 1 cycle, reco_sw=16'hB2DB, after 64 RUN cycles result=37, overflow=0, done=1.
REQ-036 reco_count=16'h3000 (12288) at LATCH -> result=9999, overflow=1.
REQ-037 Second start edge during RUN -> ignored; total busy length = 2+1+64+1 = 68 cycles.
REQ-038 abort during RUN at cycle 10 -> IDLE next cycle, busy=0, result=0, no reco_en pulse.
REQ-039 start held high across clr release -> stays IDLE; after start 1->0->1 a run starts.
REQ-040 From DONE (result=37), start edge with sw=16'h00FF -> done falls, reco_sw=16'h00FF, result stays 37 until new LATCH.
